// File: rtl/io_unit.sv
// io_unit: memory-stage I/O responder for lw_io / sw_io.
//   sw_io: out_data_i is pushed into a DEPTH-entry FIFO that drains to an
//          external sink over out_valid/out_ready.
//   lw_io: the pipeline stalls until the external source supplies a word
//          (in_valid/in_ready), which is returned on io_rdata_o/io_rvalid_o.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_i, out_i              MEM-stage instruction is lw_io / sw_io
//   out_data_i               register value to emit for sw_io
//   io_rdata_o, io_rvalid_o  captured input word and its valid strobe
//   stall_req_o              freeze PC, IF/ID, ID/EX and EX/MEM
//   in_valid, in_data, in_ready     source handshake
//   out_valid, out_data, out_ready  sink handshake
//   out_count_o              FIFO occupancy
module io_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_i,
  input  logic                       out_i,
  input  logic [DATA_W-1:0]          out_data_i,
  output logic [DATA_W-1:0]          io_rdata_o,
  output logic                       io_rvalid_o,
  output logic                       stall_req_o,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     out_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IN,
    DONE
  } in_state_t;

  in_state_t         state;
  in_state_t         state_next;
  logic              capture;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              push;
  logic              pop;

  // ---------------- input path ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdata <= '0;
    end else begin
      state <= state_next;
      if (capture) rdata <= in_data;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    io_rvalid_o = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (in_i) state_next = WAIT_IN;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        io_rvalid_o = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign io_rdata_o = rdata;

  // ---------------- output FIFO ----------------
  // Push is gated on the cycle-start count only, so a full FIFO blocks the
  // push even when a pop frees a slot in the same cycle.
  assign full      = (count == CW'(DEPTH));
  assign push      = out_i && !full;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_count_o = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= out_data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- stall ----------------
  assign stall_req_o = (in_i && (state != DONE)) || (out_i && full);

endmodule

// File: tb/tb_io_unit.sv
// tb_io_unit: randomized and directed bench for io_unit against a queue-based
// reference model of the lw_io / sw_io behaviour.
module tb_io_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_i;
  logic              out_i;
  logic [DATA_W-1:0] out_data_i;
  logic [DATA_W-1:0] io_rdata_o;
  logic              io_rvalid_o;
  logic              stall_req_o;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [$clog2(DEPTH):0] out_count_o;

  always #5 clk = ~clk;

  io_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_i(in_i), .out_i(out_i), .out_data_i(out_data_i),
    .io_rdata_o(io_rdata_o), .io_rvalid_o(io_rvalid_o), .stall_req_o(stall_req_o),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_count_o(out_count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, the lw_io transaction as
  // "waiting for a source word" / "returning a word this cycle".
  logic [DATA_W-1:0] q[$];
  bit                m_waiting;
  bit                m_returning;
  logic [DATA_W-1:0] m_word;
  bit                chk_en = 0;
  logic              seen_stall;
  logic [DATA_W-1:0] sink_log[$];

  // One clock cycle: drive at negedge, check outputs, then advance the model
  // at the following rising edge.
  task automatic step(input logic r, input logic ii, input logic oi,
                      input logic [DATA_W-1:0] od, input logic iv,
                      input logic [DATA_W-1:0] id, input logic ordy);
    bit full_now;
    @(negedge clk);
    rst = r; in_i = ii; out_i = oi; out_data_i = od;
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    full_now = (q.size() == DEPTH);
    seen_stall = stall_req_o;
    if (chk_en) begin
      check("stall", 64'(stall_req_o), 64'((ii && !m_returning) || (oi && full_now)));
      check("in_ready", 64'(in_ready), 64'(m_waiting));
      check("rvalid", 64'(io_rvalid_o), 64'(m_returning));
      check("rdata", 64'(io_rdata_o), 64'(m_word));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("count", 64'(out_count_o), 64'(q.size()));
      if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_waiting = 0; m_returning = 0; m_word = '0;
      chk_en = 1;
    end else begin
      if (q.size() != 0 && ordy) sink_log.push_back(q.pop_front());
      if (oi && !full_now) q.push_back(od);
      if (m_returning) m_returning = 0;
      else if (m_waiting) begin
        if (iv) begin m_word = id; m_waiting = 0; m_returning = 1; end
      end else if (ii) m_waiting = 1;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, ordy);
  endtask

  initial begin
    int stalls;
    int guard;
    logic [DATA_W-1:0] w;
    rst = 1'b1; in_i = 0; out_i = 0; out_data_i = '0;
    in_valid = 0; in_data = '0; out_ready = 0;

    // 1. reset, then a single push
    step(1'b1, 0, 0, '0, 0, '0, 0);
    step(1'b1, 0, 0, '0, 0, '0, 0);
    #1;
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_count", 64'(out_count_o), 64'h0);
    step(1'b0, 0, 1, 32'h11, 0, '0, 0);
    idle(0);
    check("push11_head", 64'(out_data), 64'h11);
    idle(1);

    // 2. lw_io with the source word arriving 3 cycles late
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1, 0, '0, (i == 3), 32'hDEADBEEF, 0);
      if (seen_stall === 1'b1) stalls++;
    end
    check("lw_stall_cycles", 64'(stalls), 64'd4);
    check("lw_rdata", 64'(io_rdata_o), 64'hDEADBEEF);

    // 3. FIFO full, then one pop lets the fifth push in
    guard = 0;
    while (q.size() != 0 && guard < 20) begin idle(1); guard++; end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1, 32'hA0 + i, 0, '0, 0);
    check("full_count", 64'(q.size()), 64'd4);
    step(1'b0, 0, 1, 32'hA4, 0, '0, 0);
    step(1'b0, 0, 1, 32'hA4, 0, '0, 1);
    check("full_pop_head", 64'(sink_log[$]), 64'hA0);
    step(1'b0, 0, 1, 32'hA4, 0, '0, 0);
    idle(0);

    // 4. simultaneous push/pop at count 2
    guard = 0;
    while (q.size() > 2 && guard < 20) begin idle(1); guard++; end
    step(1'b0, 0, 1, 32'hB0, 0, '0, 1);
    idle(0);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin idle(1); guard++; end

    // 5. wrap-around with out_ready toggling
    sink_log.delete();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == DEPTH) begin idle(1); end
      step(1'b0, 0, 1, 32'hC0 + i, 0, '0, 1'(i % 2));
    end
    guard = 0;
    while (q.size() != 0 && guard < 40) begin idle(1'(guard % 2)); guard++; end
    check("wrap_len", 64'(sink_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < sink_log.size(); i++) begin
      w = sink_log[i];
      check("wrap_order", 64'(w), 64'(32'hC0 + i));
    end

    // 6. reset while waiting for a source word with count 3
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1, 32'hE0 + i, 0, '0, 0);
    step(1'b0, 1, 0, '0, 0, '0, 0);
    step(1'b0, 1, 0, '0, 0, '0, 0);
    step(1'b1, 1, 0, '0, 0, '0, 0);
    step(1'b0, 0, 0, '0, 1, 32'h55, 1);
    check("rst_mid_count", 64'(out_count_o), 64'd0);
    idle(1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic ii, oi;
      if (m_waiting || m_returning) begin ii = 1; oi = 0; end
      else begin
        int sel = $urandom_range(0, 3);
        ii = (sel == 0); oi = (sel == 1 || sel == 2);
      end
      step(($urandom_range(0, 99) == 0), ii, oi, $urandom(),
           ($urandom_range(0, 2) == 0), $urandom(), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_unit.md
# io_unit

Memory-stage I/O responder that services the decoder's `lw_io` / `sw_io` requests (`in` / `out` flags carried down the pipeline).
- **Output path (`sw_io`):** register data is buffered in a small output FIFO and drained to an external sink over a valid/ready handshake.
- **Input path (`lw_io`):** the pipeline stalls until an external source supplies a word, which is then returned for register write-back.
- **Stalls:** a single stall request freezes all earlier stages whenever an I/O instruction cannot complete this cycle.

## Interface
Parameters:
- `DATA_W`, 32: width of I/O data words.
- `DEPTH`, 4: output FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_i`  in  1  current MEM-stage instruction is `lw_io`.
- `out_i`  in  1  current MEM-stage instruction is `sw_io`.
- `out_data_i`  in  DATA_W  register value to emit for `sw_io`.
- `io_rdata_o`  out  DATA_W  captured input word for write-back.
- `io_rvalid_o`  out  1  `io_rdata_o` valid this cycle.
- `stall_req_o`  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `in_valid`  in  1  external source has a word.
- `in_data`  in  DATA_W  external source word.
- `in_ready`  out  1  unit accepts a source word.
- `out_valid`  out  1  FIFO head valid toward the sink.
- `out_data`  out  DATA_W  FIFO head word.
- `out_ready`  in  1  sink accepts the head word.
- `out_count_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
General:
- `in_i` and `out_i` are never asserted together.
- When neither is asserted, the unit has no effect on the pipeline.

Input FSM, states IDLE, WAIT_IN, DONE:
- **IDLE:** on `in_i`=1, go to WAIT_IN. Stall is already asserted in this cycle.
- **WAIT_IN:** `in_ready`=1. On `in_valid && in_ready`:
  - capture `in_data` into the data register;
  - go to DONE.
  - Otherwise stay in WAIT_IN.
- **DONE:**
  - `io_rvalid_o`=1 and `io_rdata_o` = captured word;
  - no stall from the input path, so the `lw_io` instruction advances;
  - unconditional return to IDLE.
- A `lw_io` immediately following another `lw_io` re-enters WAIT_IN from IDLE and needs a fresh source word.
- `io_rdata_o` holds its last captured value outside DONE. `io_rvalid_o` is 0 outside DONE.

Output FIFO:
- Circular buffer of DEPTH entries with read pointer, write pointer and occupancy count.
- **Push:** `out_i`=1 and count < DEPTH at cycle start. `out_data_i` is written at the write pointer, and the `sw_io` completes that cycle.
- **Pop:** `out_valid && out_ready`, where `out_valid` = (count ≠ 0). `out_data` = entry at the read pointer (registered storage, no input pass-through).
- **Simultaneous push and pop:** both occur and the count is unchanged. A push is still blocked if the count was DEPTH at cycle start, even when a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.

Stall:
- `stall_req_o` = (`in_i` && state ≠ DONE) || (`out_i` && count == DEPTH).
- Combinational from the current inputs and the registered state.

Reset:
- State = IDLE.
- Pointers and count = 0.
- Data register = 0.
- Reset mid-wait abandons the pending `lw_io`.
- Reset discards all FIFO contents; no partial word is emitted.

## Timing
Reset values:
- `io_rdata_o` = 0
- `io_rvalid_o` = 0
- `stall_req_o` = 0 (given `in_i` = `out_i` = 0)
- `in_ready` = 0
- `out_valid` = 0
- `out_data` = 0 (storage cleared)
- `out_count_o` = 0

`lw_io` latency:
- Minimum 2 stall cycles: the IDLE cycle, plus a WAIT_IN cycle in which `in_valid` is already high.
- Then 1 DONE cycle with no stall.
- Every additional cycle of `in_valid` low adds one stall cycle.

`sw_io` latency:
- With the FIFO not full: 0 stall cycles.
- A pushed word appears on `out_data` with `out_valid`=1 in the cycle after the push edge.
- With the FIFO full: stall lasts until the first cycle that begins with count < DEPTH, i.e. the cycle after the first pop.

Sink handshake:
- The head word and `out_valid` are stable while `out_ready`=0.
- One word transfers per cycle at most.

Source handshake:
- A word is consumed only in a cycle where `in_valid && in_ready`.
- `in_ready` drops in the following cycle (DONE).

## Test plan
1. **Reset:** assert `rst` 2 cycles with `out_ready`=0 → every output at its reset value. Then push 0x11 → next cycle `out_valid`=1, `out_data`=0x11, `out_count_o`=1.
2. **`lw_io`, source delayed:** `in_i`=1, `in_valid` rises 3 cycles after `in_i` with `in_data`=0xDEADBEEF → `stall_req_o` high for 4 cycles, then `io_rvalid_o`=1 with `io_rdata_o`=0xDEADBEEF and `stall_req_o`=0 in the DONE cycle.
3. **FIFO full:** `out_ready`=0, push 0xA0..0xA3 → count=4. A fifth `sw_io` (0xA4) asserts stall. `out_ready`=1 for 1 cycle pops 0xA0 → stall drops the next cycle, 0xA4 pushed, count stays 4.
4. **Simultaneous push/pop:** count=2, push 0xB0 with `out_ready`=1 → count stays 2, output order preserved.
5. **Wrap-around:** 10 pushes of 0xC0+i with `out_ready` toggling every cycle → sink receives 0xC0..0xC9 in order, no loss or duplication.
6. **Reset mid-operation:** assert `rst` while in WAIT_IN with count=3 → IDLE, count=0, `out_valid`=0, no word delivered to the sink.
